commit_rob: RTL and testbench

// Reorder/commit buffer at the commit end of the execute-to-commit interface.
// - Allocates program-order tags at dispatch.
// - Absorbs out-of-order results from the two execute_to_commit_bus ports.
// - Retires up to 2 instrs/cycle in order.
// - Owns the commit_store_valid/ready handshake that releases stores held in the AGU.
// - Raises a one-cycle flush when the head instr carries an exception.

---
 rtl/commit_rob_pkg.sv | 29 ++
 rtl/commit_rob_if.sv | 36 +++
 rtl/commit_rob.sv | 128 ++++++++++++
 tb/tb_commit_rob.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_rob_pkg.sv
// Shared types for the commit-side reorder buffer: entry layout, tags/pointers
// and the completion bus carried from the execute ports.
package commit_rob_pkg;
    localparam int ROB_DEPTH = 16;
    localparam int TAG_W     = $clog2(ROB_DEPTH);

    typedef logic [TAG_W-1:0] rob_tag_t;
    // One extra MSB distinguishes full from empty when the indices match
    typedef logic [TAG_W:0]   rob_ptr_t;

    typedef struct packed {
        logic        valid;
        logic        done;
        logic        is_store;
        logic        ex;
        logic [4:0]  excode;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic [31:0] wdata;
    } rob_entry_t;

    typedef struct packed {
        logic        valid;
        rob_tag_t    tag;
        logic [31:0] wdata;
        logic        ex;
        logic [4:0]  excode;
    } execute_to_commit_bus_t;
endpackage

// File: rtl/commit_rob_if.sv
// Dispatch, completion, retire, store-release and flush signals of the ROB.
interface commit_rob_if;
    import commit_rob_pkg::*;

    logic [1:0]             disp_valid;
    logic                   disp_ready;
    logic [1:0][31:0]       disp_pc;
    logic [1:0][4:0]        disp_dest;
    logic [1:0]             disp_is_store;
    rob_tag_t [1:0]         disp_tag;
    execute_to_commit_bus_t execute_to_commit_bus1;
    execute_to_commit_bus_t execute_to_commit_bus2;
    logic [1:0]             commit_valid;
    logic [1:0][4:0]        commit_dest;
    logic [1:0][31:0]       commit_wdata;
    logic [1:0][31:0]       commit_pc;
    logic                   commit_store_valid;
    logic                   commit_store_ready;
    logic                   flush;
    logic [31:0]            flush_pc;
    logic [4:0]             flush_excode;

    modport master (
        output disp_valid, disp_pc, disp_dest, disp_is_store,
               execute_to_commit_bus1, execute_to_commit_bus2, commit_store_ready,
        input  disp_ready, disp_tag, commit_valid, commit_dest, commit_wdata,
               commit_pc, commit_store_valid, flush, flush_pc, flush_excode
    );

    modport slave (
        input  disp_valid, disp_pc, disp_dest, disp_is_store,
               execute_to_commit_bus1, execute_to_commit_bus2, commit_store_ready,
        output disp_ready, disp_tag, commit_valid, commit_dest, commit_wdata,
               commit_pc, commit_store_valid, flush, flush_pc, flush_excode
    );
endinterface

// File: rtl/commit_rob.sv
// Reorder/commit buffer: in-order 2-wide dispatch and retire, out-of-order
// completion from two execute ports, store release handshake and exception flush.
module commit_rob
    import commit_rob_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    commit_rob_if.slave rob_io
);
    localparam rob_ptr_t READY_MAX = rob_ptr_t'(ROB_DEPTH - 2);

    rob_entry_t ent_q [ROB_DEPTH];
    rob_entry_t ent_d [ROB_DEPTH];
    rob_ptr_t   head_q, head_d;
    rob_ptr_t   tail_q, tail_d;

    rob_ptr_t               used;
    rob_tag_t               head_idx, tail_idx;
    rob_entry_t             slot_e [2];
    execute_to_commit_bus_t bus [2];
    logic [1:0]             ret;
    logic [1:0]             disp_fire;
    logic                   disp_rdy;
    logic                   exc0;
    logic                   store0;

    assign used     = tail_q - head_q;
    assign disp_rdy = (used <= READY_MAX);
    assign head_idx = head_q[TAG_W-1:0];
    assign tail_idx = tail_q[TAG_W-1:0];
    assign slot_e[0] = ent_q[head_idx];
    assign slot_e[1] = ent_q[head_idx + rob_tag_t'(1)];
    assign bus[0]    = rob_io.execute_to_commit_bus1;
    assign bus[1]    = rob_io.execute_to_commit_bus2;

    // Freed entries always have valid cleared, so an empty buffer never retires
    assign exc0   = slot_e[0].valid && slot_e[0].done && slot_e[0].ex;
    assign store0 = slot_e[0].valid && slot_e[0].done && !slot_e[0].ex && slot_e[0].is_store;
    assign ret[0] = slot_e[0].valid && slot_e[0].done && !slot_e[0].ex &&
                    (!slot_e[0].is_store || rob_io.commit_store_ready);
    assign ret[1] = ret[0] && slot_e[1].valid && slot_e[1].done &&
                    !slot_e[1].ex && !slot_e[1].is_store;

    assign disp_fire[0] = rob_io.disp_valid[0] && disp_rdy && !exc0;
    assign disp_fire[1] = disp_fire[0] && rob_io.disp_valid[1];

    assign rob_io.disp_ready         = disp_rdy;
    assign rob_io.commit_store_valid = store0;
    assign rob_io.flush              = exc0;
    assign rob_io.flush_pc           = exc0 ? slot_e[0].pc : '0;
    assign rob_io.flush_excode       = exc0 ? slot_e[0].excode : '0;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            assign rob_io.commit_valid[gi] = ret[gi];
            assign rob_io.commit_dest[gi]  = ret[gi] ? slot_e[gi].dest  : '0;
            assign rob_io.commit_wdata[gi] = ret[gi] ? slot_e[gi].wdata : '0;
            assign rob_io.commit_pc[gi]    = ret[gi] ? slot_e[gi].pc    : '0;
            assign rob_io.disp_tag[gi]     = disp_fire[gi] ? (tail_idx + rob_tag_t'(gi)) : '0;
        end
    endgenerate

    always_comb begin
        ent_d  = ent_q;
        head_d = head_q;
        tail_d = tail_q;
        if (exc0) begin
            // Flush discards everything, including this cycle's dispatch and completions
            head_d = '0;
            tail_d = '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
                ent_d[i].done  = 1'b0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (bus[b].valid && ent_q[bus[b].tag].valid) begin
                    ent_d[bus[b].tag].done   = 1'b1;
                    ent_d[bus[b].tag].wdata  = bus[b].wdata;
                    ent_d[bus[b].tag].ex     = bus[b].ex;
                    ent_d[bus[b].tag].excode = bus[b].excode;
                end
            end
            for (int s = 0; s < 2; s++) begin
                if (ret[s]) begin
                    ent_d[head_idx + rob_tag_t'(s)].valid = 1'b0;
                    ent_d[head_idx + rob_tag_t'(s)].done  = 1'b0;
                end
            end
            for (int s = 0; s < 2; s++) begin
                if (disp_fire[s]) begin
                    ent_d[tail_idx + rob_tag_t'(s)] = '{
                        valid:    1'b1,
                        done:     1'b0,
                        is_store: rob_io.disp_is_store[s],
                        ex:       1'b0,
                        excode:   5'd0,
                        dest:     rob_io.disp_dest[s],
                        pc:       rob_io.disp_pc[s],
                        wdata:    32'd0
                    };
                end
            end
            head_d = head_q + rob_ptr_t'(ret[0]) + rob_ptr_t'(ret[1]);
            tail_d = tail_q + rob_ptr_t'(disp_fire[0]) + rob_ptr_t'(disp_fire[1]);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    // Two completions for one tag in the same cycle cannot both be honoured
    assert property (@(posedge clk) disable iff (!resetn)
        !(bus[0].valid && bus[1].valid && (bus[0].tag == bus[1].tag)));
endmodule

// File: tb/tb_commit_rob.sv
// Directed bench for commit_rob: dispatch/complete/retire, fill and wrap,
// store release, exception flush and asynchronous reset.
module tb_commit_rob;
    import commit_rob_pkg::*;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    commit_rob_if rif ();

    commit_rob dut (
        .clk    (clk),
        .resetn (resetn),
        .rob_io (rif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle();
        rif.disp_valid             = '0;
        rif.disp_pc                = '0;
        rif.disp_dest              = '0;
        rif.disp_is_store          = '0;
        rif.execute_to_commit_bus1 = '0;
        rif.execute_to_commit_bus2 = '0;
        rif.commit_store_ready     = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic disp(input int n, input logic [31:0] pc0, input logic [4:0] d0, input logic s0,
                        input logic [31:0] pc1, input logic [4:0] d1, input logic s1);
        rif.disp_valid       = (n == 2) ? 2'b11 : 2'b01;
        rif.disp_pc[0]       = pc0;
        rif.disp_dest[0]     = d0;
        rif.disp_is_store[0] = s0;
        rif.disp_pc[1]       = pc1;
        rif.disp_dest[1]     = d1;
        rif.disp_is_store[1] = s1;
    endtask

    task automatic comp(input int port, input int tag, input logic [31:0] wd,
                        input logic ex, input logic [4:0] code);
        execute_to_commit_bus_t b;
        b.valid  = 1'b1;
        b.tag    = rob_tag_t'(tag);
        b.wdata  = wd;
        b.ex     = ex;
        b.excode = code;
        if (port == 1) rif.execute_to_commit_bus1 = b;
        else           rif.execute_to_commit_bus2 = b;
    endtask

    initial begin
        idle();
        resetn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_cv",    rif.commit_valid, 0);
        chk("rst_sv",    rif.commit_store_valid, 0);
        chk("rst_flush", rif.flush, 0);
        chk("rst_fpc",   rif.flush_pc, 0);
        chk("rst_rdy",   rif.disp_ready, 1);
        chk("rst_tag",   rif.disp_tag, 0);
        @(negedge clk);
        resetn = 1'b1;

        // Two ALU ops completing out of order retire together
        step(); disp(2, 32'h100, 5'd1, 1'b0, 32'h104, 5'd2, 1'b0); #1;
        chk("t1_tag", rif.disp_tag, 8'h10);
        chk("t1_rdy", rif.disp_ready, 1);
        step(); comp(1, 1, 32'hB, 1'b0, 5'd0); #1;
        chk("t1_cv_a", rif.commit_valid, 0);
        step(); comp(1, 0, 32'hA, 1'b0, 5'd0); #1;
        chk("t1_cv_b", rif.commit_valid, 0);
        step(); #1;
        chk("t1_cv",   rif.commit_valid, 2'b11);
        chk("t1_wd",   rif.commit_wdata, {32'hB, 32'hA});
        chk("t1_dest", rif.commit_dest, {5'd2, 5'd1});
        chk("t1_pc",   rif.commit_pc, {32'h104, 32'h100});
        step(); #1;
        chk("t1_empty", rif.commit_valid, 0);

        // Completion, dispatch and retire on the same edge
        step(); disp(2, 32'h200, 5'd3, 1'b0, 32'h204, 5'd4, 1'b0); #1;
        chk("t5_tag_a", rif.disp_tag, 8'h32);
        step(); disp(1, 32'h208, 5'd5, 1'b0, 32'h0, 5'd0, 1'b0); comp(1, 2, 32'h22, 1'b0, 5'd0); #1;
        chk("t5_tag_b", rif.disp_tag, 8'h04);
        step(); disp(1, 32'h20C, 5'd6, 1'b0, 32'h0, 5'd0, 1'b0);
        comp(1, 3, 32'h33, 1'b0, 5'd0); comp(2, 4, 32'h44, 1'b0, 5'd0); #1;
        chk("t5_cv_a",  rif.commit_valid, 2'b01);
        chk("t5_wd_a",  rif.commit_wdata[0], 32'h22);
        chk("t5_tag_c", rif.disp_tag, 8'h05);
        step(); #1;
        chk("t5_cv_b", rif.commit_valid, 2'b11);
        chk("t5_wd_b", rif.commit_wdata, {32'h44, 32'h33});
        chk("t5_pc_b", rif.commit_pc, {32'h208, 32'h204});
        step(); comp(1, 5, 32'h55, 1'b0, 5'd0); #1;
        chk("t5_cv_c", rif.commit_valid, 0);
        step(); #1;
        chk("t5_cv_d", rif.commit_valid, 2'b01);
        chk("t5_pc_d", rif.commit_pc[0], 32'h20C);
        step(); #1;
        chk("t5_empty", rif.commit_valid, 0);

        // Store held at head until the AGU accepts it
        step(); disp(1, 32'h300, 5'd0, 1'b1, 32'h0, 5'd0, 1'b0); #1;
        chk("t3_tag", rif.disp_tag, 8'h06);
        step(); comp(1, 6, 32'h0, 1'b0, 5'd0); #1;
        chk("t3_sv_pre", rif.commit_store_valid, 0);
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            chk("t3_sv_hold", rif.commit_store_valid, 1);
            chk("t3_cv_hold", rif.commit_valid, 0);
        end
        step(); rif.commit_store_ready = 1'b1; #1;
        chk("t3_sv_hs", rif.commit_store_valid, 1);
        chk("t3_cv_hs", rif.commit_valid, 2'b01);
        chk("t3_pc_hs", rif.commit_pc[0], 32'h300);
        step(); #1;
        chk("t3_sv_post", rif.commit_store_valid, 0);
        chk("t3_cv_post", rif.commit_valid, 0);

        // Exception at head flushes and empties the buffer
        step(); disp(2, 32'hBFC00100, 5'd7, 1'b0, 32'h404, 5'd8, 1'b0); #1;
        chk("t4_tag_a", rif.disp_tag, 8'h87);
        step(); comp(1, 7, 32'h0, 1'b1, 5'h04); comp(2, 8, 32'h88, 1'b0, 5'd0); #1;
        chk("t4_flush_pre", rif.flush, 0);
        step(); disp(2, 32'h500, 5'd9, 1'b0, 32'h504, 5'd10, 1'b0); #1;
        chk("t4_flush", rif.flush, 1);
        chk("t4_fpc",   rif.flush_pc, 32'hBFC00100);
        chk("t4_fexc",  rif.flush_excode, 5'h04);
        chk("t4_cv",    rif.commit_valid, 0);
        chk("t4_sv",    rif.commit_store_valid, 0);
        step(); #1;
        chk("t4_flush_off", rif.flush, 0);
        chk("t4_cv_off",    rif.commit_valid, 0);
        chk("t4_rdy",       rif.disp_ready, 1);
        step(); disp(2, 32'h600, 5'd1, 1'b0, 32'h604, 5'd2, 1'b0); #1;
        chk("t4_tag_b", rif.disp_tag, 8'h10);
        step(); comp(1, 0, 32'h60, 1'b0, 5'd0); comp(2, 1, 32'h61, 1'b0, 5'd0); #1;
        step(); #1;
        chk("t4_cv_b", rif.commit_valid, 2'b11);
        chk("t4_pc_b", rif.commit_pc, {32'h604, 32'h600});
        step(); disp(2, 32'h700, 5'd3, 1'b0, 32'h704, 5'd4, 1'b0); #1;
        chk("t4_tag_c", rif.disp_tag, 8'h32);
        step(); comp(1, 2, 32'h70, 1'b0, 5'd0); comp(2, 3, 32'h0, 1'b1, 5'h07); #1;
        step(); #1;
        chk("t4_cv_c",    rif.commit_valid, 2'b01);
        chk("t4_flush_c", rif.flush, 0);
        chk("t4_pc_c",    rif.commit_pc[0], 32'h700);
        step(); #1;
        chk("t4_flush_d", rif.flush, 1);
        chk("t4_fexc_d",  rif.flush_excode, 5'h07);
        chk("t4_fpc_d",   rif.flush_pc, 32'h704);
        chk("t4_cv_d",    rif.commit_valid, 0);
        step(); #1;
        chk("t4_flush_e", rif.flush, 0);

        // Fill to 15 entries, drain, then wrap the tail past the last index
        for (int i = 0; i < 7; i++) begin
            step();
            disp(2, 32'h1000 + 32'(8 * i), 5'(2 * i + 1), 1'b0,
                    32'h1004 + 32'(8 * i), 5'(2 * i + 2), 1'b0);
            #1;
            chk("t2_rdy_fill", rif.disp_ready, 1);
        end
        step(); disp(1, 32'h1038, 5'd15, 1'b0, 32'h0, 5'd0, 1'b0); #1;
        chk("t2_rdy_14", rif.disp_ready, 1);
        chk("t2_tag_14", rif.disp_tag, 8'h0E);
        step(); disp(2, 32'h2000, 5'd1, 1'b0, 32'h2004, 5'd2, 1'b0); #1;
        chk("t2_rdy_15", rif.disp_ready, 0);
        chk("t2_tag_blk", rif.disp_tag, 0);
        for (int k = 0; k <= 8; k++) begin
            step();
            if (k <= 6) begin
                comp(1, 2 * k, 32'(2 * k), 1'b0, 5'd0);
                comp(2, 2 * k + 1, 32'(2 * k + 1), 1'b0, 5'd0);
            end else if (k == 7) begin
                comp(1, 14, 32'd14, 1'b0, 5'd0);
            end
            #1;
            if (k == 0) begin
                chk("t2_cv_k0", rif.commit_valid, 0);
            end else if (k == 8) begin
                chk("t2_cv_k8", rif.commit_valid, 2'b01);
                chk("t2_pc_k8", rif.commit_pc[0], 32'h1038);
            end else begin
                chk("t2_cv_k", rif.commit_valid, 2'b11);
                chk("t2_pc_k", rif.commit_pc[0], 32'h1000 + 32'(8 * (k - 1)));
            end
            if (k == 1) chk("t2_rdy_k1", rif.disp_ready, 0);
        end
        step(); disp(2, 32'h3000, 5'd20, 1'b0, 32'h3004, 5'd21, 1'b0); #1;
        chk("t2_tag_wrap", rif.disp_tag, 8'h0F);
        chk("t2_rdy_wrap", rif.disp_ready, 1);
        step(); disp(2, 32'h3008, 5'd22, 1'b0, 32'h300C, 5'd23, 1'b0);
        comp(1, 15, 32'hF, 1'b0, 5'd0); comp(2, 0, 32'hF0, 1'b0, 5'd0); #1;
        chk("t2_tag_post", rif.disp_tag, 8'h21);
        chk("t2_rdy_post", rif.disp_ready, 1);
        step(); comp(1, 1, 32'hF1, 1'b0, 5'd0); comp(2, 2, 32'hF2, 1'b0, 5'd0); #1;
        chk("t2_cv_w1",   rif.commit_valid, 2'b11);
        chk("t2_pc_w1",   rif.commit_pc, {32'h3004, 32'h3000});
        chk("t2_dest_w1", rif.commit_dest, {5'd21, 5'd20});
        chk("t2_wd_w1",   rif.commit_wdata, {32'hF0, 32'hF});
        step(); #1;
        chk("t2_cv_w2", rif.commit_valid, 2'b11);
        chk("t2_pc_w2", rif.commit_pc, {32'h300C, 32'h3008});
        step(); #1;
        chk("t2_empty", rif.commit_valid, 0);

        // Asynchronous reset with eight entries in flight
        for (int i = 0; i < 4; i++) begin
            step();
            disp(2, 32'h4000 + 32'(8 * i), 5'd1, 1'b0, 32'h4004 + 32'(8 * i), 5'd2, 1'b0);
            #1;
            if (i == 0) chk("t6_tag", rif.disp_tag, 8'h43);
        end
        step(); comp(1, 3, 32'h77, 1'b0, 5'd0); #1;
        step(); #1;
        chk("t6_cv_pre", rif.commit_valid, 2'b01);
        #1;
        resetn = 1'b0;
        #1;
        chk("t6_cv",    rif.commit_valid, 0);
        chk("t6_wd",    rif.commit_wdata, 0);
        chk("t6_pc",    rif.commit_pc, 0);
        chk("t6_sv",    rif.commit_store_valid, 0);
        chk("t6_flush", rif.flush, 0);
        chk("t6_tag_r", rif.disp_tag, 0);
        @(negedge clk);
        resetn = 1'b1;
        step(); disp(2, 32'h5000, 5'd1, 1'b0, 32'h5004, 5'd2, 1'b0); #1;
        chk("t6_rdy",    rif.disp_ready, 1);
        chk("t6_cv_rel", rif.commit_valid, 0);
        chk("t6_tag_rel", rif.disp_tag, 8'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
